mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Initiator side of the on-board byte RAM port. Accepts one 8/16/32-bit load or store from the core's memory stage, serialises it into consecutive little-endian byte accesses on the RAM's `en`/`r_nw`/`a`/`d` interface, and compensates for the RAM's one-cycle synchronous read latency. Returns one response per request: assembled, extended read data for loads, or a completion pulse for stores. Sits between the core/LSU arbiter and `ram`.

## Interface
- `ADDR_WIDTH`, default 17: RAM address width; request addresses are truncated to it.
- `clk_in` in 1: system clock; all logic on the rising edge.
- `rst_n_in` in 1: reset, synchronous, active-low.
- `rdy_in` in 1: global run enable; low freezes the block.
- `req_valid_in` in 1: request present.
- `req_ready_out` out 1: request accepted on any edge where valid and ready are both high.
- `req_we_in` in 1: 1 = store, 0 = load.
- `req_size_in` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_signed_in` in 1: sign-extend load data (byte/half only).
- `req_addr_in` in 32: byte address; any alignment is legal.
- `req_wdata_in` in 32: store data; the low `n` bytes are used.
- `resp_valid_out` out 1: one-cycle completion pulse.
- `resp_rdata_out` out 32: load result, valid with `resp_valid_out`; 0 for stores.
- `ram_en_out` out 1: RAM chip enable.
- `ram_r_nw_out` out 1: 1 = read, 0 = write.
- `ram_a_out` out ADDR_WIDTH: RAM byte address.
- `ram_d_out` out 8: RAM write data.
- `ram_d_in` in 8: RAM read data; holds the byte addressed in the previous cycle.

## Operation
- **FSM states:** IDLE, RD, RD_TAIL, WR.
- **IDLE**
  - `req_ready_out = (state==IDLE) & rdy_in & rst_n_in`.
  - On handshake, latch address, size (`n` = 1/2/4), signed flag, and write data; clear the byte counter `i`.
  - Go to WR if `req_we_in`, else RD.
- **WR**
  - Each cycle drive `en=1`, `r_nw=0`, `a = addr+i`, `d = wdata[8i+7:8i]`.
  - After byte `n-1`, return to IDLE and pulse `resp_valid_out` on the next cycle.
- **RD**
  - Each cycle drive `en=1`, `r_nw=1`, `a = addr+i`.
  - From the second RD cycle on, capture `ram_d_in` into byte `i-1` of the assembly register.
  - After issuing byte `n-1`, go to RD_TAIL.
- **RD_TAIL**
  - Drive `en=0`.
  - Capture byte `n-1`, then go to IDLE with the response pulse.
- **Read data extension**
  - Byte `k` maps to `rdata[8k+7:8k]`.
  - Size byte: upper 24 bits are zero, or copies of bit 7 if signed.
  - Size half: upper 16 bits are zero, or copies of bit 15 if signed.
  - Size word: `req_signed_in` is ignored.
- **Address arithmetic:** `addr+i` is computed in ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH. A word at 0x1FFFF touches 0x1FFFF, 0x00000, 0x00001, 0x00002.
- **Outputs in IDLE:** `ram_en_out=0`, `ram_r_nw_out=1`, `ram_a_out` holds its last value, `ram_d_out=0`.
- **Reset:** every registered output goes to 0, except `ram_r_nw_out=1`. State goes to IDLE.
- **Reset mid-operation:** the transaction is dropped and no response is issued. Bytes already written stay written.
- **`rdy_in` low:**
  - All state, counters and the assembly register hold.
  - `ram_en_out` is forced to 0.
  - `ram_a_out` holds, so the pending RAM read data remains valid when `rdy_in` returns.
- **Back-to-back requests:** a new request may be accepted in the same cycle `resp_valid_out` is high.

## Timing
- Handshake at edge 0; RAM accesses occupy cycles 1..n, with one byte per cycle and no gaps.
- **Store latency:** `resp_valid_out` is high during cycle n+1. Byte store → cycle 2; word store → cycle 5.
- **Load latency:** `resp_valid_out` is high during cycle n+2. Byte load → cycle 3; word load → cycle 6.
- **`resp_rdata_out`:** registered; holds its value until the next response.
- **Effect of `rdy_in`:** each stalled cycle adds exactly one cycle to the latency.

## Structure
- **Shared package `mem_pkg`:**
  - Size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`.
  - The FSM state enum.
  - Constant `RAM_ADDR_WIDTH = 17`.
- **Sub-module `mem_rdext`:** combinational byte/half/word zero/sign extender, reused later by the LSU.
- **Storage:** the assembly register and byte counter live in `mem_ctrl`.

## Test plan
- Word load at 0x00010, with RAM holding 0x11,0x22,0x33,0x84 at 0x10..0x13 → RAM addresses 0x10..0x13 in cycles 1–4; response cycle 6 with `rdata=0x84332211`.
- Signed byte load at 0x13 → response cycle 3 with `0xFFFFFF84`. Unsigned half load at 0x12 → `0x00008433`.
- Word store of 0xDEADBEEF at 0x1FFFF → writes 0xEF@0x1FFFF, 0xBE@0x0, 0xAD@0x1, 0xDE@0x2; `resp_valid_out` in cycle 5.
- Word load with `rdy_in` low for 3 cycles after cycle 2 → no RAM writes during the stall, correct data, response in cycle 9.
- `rst_n_in` low in cycle 3 of a word store → only bytes 0–1 written, no response, `req_ready_out` high the cycle after reset releases.
- Two back-to-back byte stores, the second presented while the first's response is high → the second's RAM write occurs in the cycle after acceptance, with no idle gap.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-RAM initiator and the load data extender.
package mem_pkg;

  localparam int RAM_ADDR_WIDTH = 17;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_RD_TAIL = 2'd2,
    ST_WR      = 2'd3
  } mem_state_t;

  // Index of the last byte of an access; encoding 3 behaves as a word.
  function automatic logic [1:0] size_last(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_rdext.sv
// Combinational zero/sign extender for byte, half and word load data.
module mem_rdext
  import mem_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [1:0]  size_in,
  input  logic        sign_in,
  output logic [31:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (size_in)
      SZ_BYTE: data_out = {{24{sign_in & data_in[7]}}, data_in[7:0]};
      SZ_HALF: data_out = {{16{sign_in & data_in[15]}}, data_in[15:0]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Serialises one 8/16/32-bit load/store into little-endian byte accesses on
// the synchronous byte RAM and returns a single response per request.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_we_in,
  input  logic [1:0]            req_size_in,
  input  logic                  req_signed_in,
  input  logic [31:0]           req_addr_in,
  input  logic [31:0]           req_wdata_in,
  output logic                  resp_valid_out,
  output logic [31:0]           resp_rdata_out,
  output logic                  ram_en_out,
  output logic                  ram_r_nw_out,
  output logic [ADDR_WIDTH-1:0] ram_a_out,
  output logic [7:0]            ram_d_out,
  input  logic [7:0]            ram_d_in,
  output mem_state_t            dbg_state_out
);

  // Request handshake: a request transfers on any rising edge where
  // req_valid_in and req_ready_out are both high; ready never depends on valid.

  mem_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] last_a_q, last_a_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            last_q, last_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           asm_q, asm_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  resp_valid_q, resp_valid_d;

  logic                  handshake;
  logic                  busy;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] cur_a;
  logic [1:0]            cap_idx;
  logic [31:0]           cap_asm;
  logic [31:0]           ext_data;
  logic                  addr_unused;

  assign addr_unused   = ^req_addr_in[31:ADDR_WIDTH];
  assign req_ready_out = (state_q == ST_IDLE) & rdy_in & rst_n_in;
  assign handshake     = req_valid_in & req_ready_out;
  assign busy          = (state_q == ST_RD) | (state_q == ST_WR);
  assign issue         = busy & rdy_in & rst_n_in;
  assign cur_a         = addr_q + ADDR_WIDTH'(cnt_q);

  // RAM data lags its address by a cycle, so RD captures the previous byte.
  assign cap_idx = (state_q == ST_RD_TAIL) ? last_q : (cnt_q - 2'd1);
  always_comb begin
    cap_asm = asm_q;
    cap_asm[{cap_idx, 3'b000} +: 8] = ram_d_in;
  end

  mem_rdext u_rdext (
    .data_in  (cap_asm),
    .size_in  (size_q),
    .sign_in  (signed_q),
    .data_out (ext_data)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      case (state_q)
        ST_IDLE:    if (handshake) state_d = req_we_in ? ST_WR : ST_RD;
        ST_RD:      if (cnt_q == last_q) state_d = ST_RD_TAIL;
        ST_RD_TAIL: state_d = ST_IDLE;
        ST_WR:      if (cnt_q == last_q) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    asm_d        = asm_q;
    rdata_d      = rdata_q;
    resp_valid_d = resp_valid_q;
    last_a_d     = issue ? cur_a : last_a_q;
    if (rdy_in) begin
      resp_valid_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            addr_d   = req_addr_in[ADDR_WIDTH-1:0];
            size_d   = req_size_in;
            last_d   = size_last(req_size_in);
            signed_d = req_signed_in;
            wdata_d  = req_wdata_in;
            cnt_d    = 2'd0;
            asm_d    = 32'd0;
          end
        end
        ST_RD: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q != 2'd0) asm_d = cap_asm;
        end
        ST_RD_TAIL: begin
          asm_d        = cap_asm;
          rdata_d      = ext_data;
          resp_valid_d = 1'b1;
        end
        ST_WR: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == last_q) begin
            rdata_d      = 32'd0;
            resp_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      addr_q       <= '0;
      last_a_q     <= '0;
      cnt_q        <= 2'd0;
      last_q       <= 2'd0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      wdata_q      <= 32'd0;
      asm_q        <= 32'd0;
      rdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      last_a_q     <= last_a_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      asm_q        <= asm_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // The address parks on the last issued byte whenever nothing is issued,
  // keeping the pending read data stable across stalls.
  always_comb begin
    ram_en_out     = issue;
    ram_r_nw_out   = ~(issue & (state_q == ST_WR));
    ram_a_out      = issue ? cur_a : last_a_q;
    ram_d_out      = (issue & (state_q == ST_WR)) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    resp_valid_out = resp_valid_q;
    resp_rdata_out = rdata_q;
    dbg_state_out  = state_q;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural synchronous byte RAM.
module tb_mem_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        ram_en, ram_r_nw;
  logic [16:0] ram_a;
  logic [7:0]  ram_d, ram_dout;
  mem_state_t  dbg_state;

  logic [7:0]  mem [0:131071];
  int          wr_count = 0;
  int          w0;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_r_nw) ram_dout <= mem[ram_a];
      else begin
        mem[ram_a] <= ram_d;
        wr_count   <= wr_count + 1;
      end
    end
  end

  mem_ctrl #(.ADDR_WIDTH(17)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy),
    .req_valid_in   (req_valid),
    .req_ready_out  (req_ready),
    .req_we_in      (req_we),
    .req_size_in    (req_size),
    .req_signed_in  (req_signed),
    .req_addr_in    (req_addr),
    .req_wdata_in   (req_wdata),
    .resp_valid_out (resp_valid),
    .resp_rdata_out (resp_rdata),
    .ram_en_out     (ram_en),
    .ram_r_nw_out   (ram_r_nw),
    .ram_a_out      (ram_a),
    .ram_d_out      (ram_d),
    .ram_d_in       (ram_dout),
    .dbg_state_out  (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic en, input logic rnw,
                         input logic [16:0] a, input logic [7:0] d);
    chk(tag, {5'b0, ram_en, ram_r_nw, ram_a, ram_d}, {5'b0, en, rnw, a, d});
  endtask

  task automatic to_drive;
    @(posedge clk);
    #1;
  endtask

  task automatic to_check;
    @(negedge clk);
  endtask

  // Presents a request in cycle 0 and returns at the drive point of cycle 1.
  task automatic handshake(input string tag, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    to_drive;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    to_check;
    chk(tag, {31'd0, req_ready}, 32'd1);
    to_drive;
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;

    // Reset state
    to_drive;
    to_check;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk_bus("rst_bus", 1'b0, 1'b1, 17'h0, 8'h00);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    to_drive;
    rst_n = 1'b1;
    to_check;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Word store 0x84332211 at 0x10 lays down the bytes the loads use
    handshake("st1_rdy", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h84332211);
    for (int k = 0; k < 4; k++) begin
      to_check;
      chk_bus("st1_bus", 1'b1, 1'b0, 17'(32'h10 + k), 8'(32'h84332211 >> (8 * k)));
      chk("st1_resp_lo", {31'd0, resp_valid}, 32'd0);
      to_drive;
    end
    to_check;
    chk("st1_resp", {31'd0, resp_valid}, 32'd1);
    chk("st1_rdata", resp_rdata, 32'd0);
    chk_bus("st1_idle_bus", 1'b0, 1'b1, 17'h13, 8'h00);

    // Word load at 0x10: addresses in cycles 1..4, response in cycle 6
    handshake("ld1_rdy", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    for (int k = 0; k < 4; k++) begin
      to_check;
      chk_bus("ld1_bus", 1'b1, 1'b1, 17'(32'h10 + k), 8'h00);
      if (k == 0) chk("ld1_state", 32'(dbg_state), 32'(ST_RD));
      to_drive;
    end
    to_check;
    chk_bus("ld1_tail_bus", 1'b0, 1'b1, 17'h13, 8'h00);
    chk("ld1_tail_resp", {31'd0, resp_valid}, 32'd0);
    to_drive;
    to_check;
    chk("ld1_resp", {31'd0, resp_valid}, 32'd1);
    chk("ld1_rdata", resp_rdata, 32'h84332211);
    to_drive;
    to_check;
    chk("ld1_resp_end", {31'd0, resp_valid}, 32'd0);
    chk("ld1_rdata_hold", resp_rdata, 32'h84332211);

    // Signed byte load at 0x13: response in cycle 3
    handshake("ldb_rdy", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0);
    to_check;
    chk_bus("ldb_bus", 1'b1, 1'b1, 17'h13, 8'h00);
    to_drive;
    to_check;
    chk("ldb_tail_resp", {31'd0, resp_valid}, 32'd0);
    to_drive;
    to_check;
    chk("ldb_resp", {31'd0, resp_valid}, 32'd1);
    chk("ldb_rdata", resp_rdata, 32'hFFFFFF84);

    // Unsigned then signed half loads at 0x12
    handshake("ldhu_rdy", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0);
    to_check; to_drive;
    to_check; to_drive;
    to_check; to_drive;
    to_check;
    chk("ldhu_resp", {31'd0, resp_valid}, 32'd1);
    chk("ldhu_rdata", resp_rdata, 32'h00008433);
    handshake("ldhs_rdy", 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0);
    to_check; to_drive;
    to_check; to_drive;
    to_check; to_drive;
    to_check;
    chk("ldhs_resp", {31'd0, resp_valid}, 32'd1);
    chk("ldhs_rdata", resp_rdata, 32'hFFFF8433);

    // Word store across the top of the address space
    handshake("stw_rdy", 1'b1, SZ_WORD, 1'b0, 32'h1FFFF, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      to_check;
      chk_bus("stw_bus", 1'b1, 1'b0, 17'(32'h1FFFF + k), 8'(32'hDEADBEEF >> (8 * k)));
      to_drive;
    end
    to_check;
    chk("stw_resp", {31'd0, resp_valid}, 32'd1);
    chk("stw_mem_top", {24'd0, mem[17'h1FFFF]}, 32'hEF);
    chk("stw_mem_wrap", {24'd0, mem[17'h00002]}, 32'hDE);

    // Wrapping word load with rdy low for cycles 3..5: response in cycle 9
    handshake("stall_rdy", 1'b0, SZ_WORD, 1'b0, 32'h1FFFF, 32'h0);
    to_check;
    chk_bus("stall_c1", 1'b1, 1'b1, 17'h1FFFF, 8'h00);
    to_drive;
    to_check;
    chk_bus("stall_c2", 1'b1, 1'b1, 17'h00000, 8'h00);
    to_drive;
    rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      to_check;
      chk_bus("stall_hold", 1'b0, 1'b1, 17'h00000, 8'h00);
      chk("stall_resp", {31'd0, resp_valid}, 32'd0);
      to_drive;
    end
    rdy = 1'b1;
    to_check;
    chk_bus("stall_c6", 1'b1, 1'b1, 17'h00001, 8'h00);
    to_drive;
    to_check;
    chk_bus("stall_c7", 1'b1, 1'b1, 17'h00002, 8'h00);
    to_drive;
    to_check;
    chk("stall_c8_resp", {31'd0, resp_valid}, 32'd0);
    to_drive;
    to_check;
    chk("stall_c9_resp", {31'd0, resp_valid}, 32'd1);
    chk("stall_rdata", resp_rdata, 32'hDEADBEEF);

    // Reset during cycle 3 of a word store
    w0 = wr_count;
    handshake("rstw_rdy", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344);
    to_check;
    chk_bus("rstw_c1", 1'b1, 1'b0, 17'h20, 8'h44);
    to_drive;
    to_check;
    chk_bus("rstw_c2", 1'b1, 1'b0, 17'h21, 8'h33);
    to_drive;
    rst_n = 1'b0;
    to_check;
    chk("rstw_en", {31'd0, ram_en}, 32'd0);
    to_drive;
    rst_n = 1'b1;
    to_check;
    chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_resp", {31'd0, resp_valid}, 32'd0);
    chk("rstw_rdata", resp_rdata, 32'd0);
    chk_bus("rstw_bus", 1'b0, 1'b1, 17'h0, 8'h00);
    to_drive;
    to_check;
    chk("rstw_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("rstw_writes", 32'(wr_count - w0), 32'd2);
    chk("rstw_mem0", {24'd0, mem[17'h20]}, 32'h44);
    chk("rstw_mem1", {24'd0, mem[17'h21]}, 32'h33);

    // Back-to-back byte stores, second accepted while first responds
    handshake("b2b_rdy1", 1'b1, SZ_BYTE, 1'b0, 32'h30, 32'hA5);
    to_check;
    chk_bus("b2b_c1", 1'b1, 1'b0, 17'h30, 8'hA5);
    to_drive;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_addr = 32'h31; req_wdata = 32'h5A;
    to_check;
    chk("b2b_resp1", {31'd0, resp_valid}, 32'd1);
    chk("b2b_rdy2", {31'd0, req_ready}, 32'd1);
    to_drive;
    req_valid = 1'b0;
    to_check;
    chk_bus("b2b_c3", 1'b1, 1'b0, 17'h31, 8'h5A);
    chk("b2b_c3_resp", {31'd0, resp_valid}, 32'd0);
    to_drive;
    to_check;
    chk("b2b_resp2", {31'd0, resp_valid}, 32'd1);
    chk("b2b_mem", {16'd0, mem[17'h31], mem[17'h30]}, 32'h5AA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
